// File: rtl/csa_accum_pipe.sv
// Multi-operand carry-save accumulator: operands are folded into redundant C/S
// vectors, then resolved to binary one CHUNK per cycle and handed out on valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; results of the last run are held
// ACCUM   | accepting operands into the 3:2 compression row
// RESOLVE | carry-propagating C+S into out_sum, one chunk per cycle
// DONE    | result presented until the consumer takes it
module csa_accum_pipe #(
    parameter int WIDTH = 184,
    parameter int CHUNK = 46,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   c_q, s_q, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               cy_q;

    logic               accept;
    logic               last_chunk;
    logic [WIDTH-1:0]   s_nxt, maj;
    logic [CHUNK-1:0]   s_chunk, c_chunk;
    logic [CHUNK:0]     chunk_sum;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = sum_q;
    assign out_count = cnt_q;

    assign accept     = in_ready && in_valid;
    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

    // 3:2 compression of {S, C, operand}; the shifted-out carry is mod 2^WIDTH
    assign s_nxt = s_q ^ c_q ^ in_data;
    assign maj   = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);

    assign s_chunk   = s_q[idx_q*CHUNK +: CHUNK];
    assign c_chunk   = c_q[idx_q*CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
            RESOLVE: if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            s_q   <= '0;
            sum_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            cy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        c_q   <= '0;
                        s_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        s_q <= s_nxt;
                        c_q <= {maj[WIDTH-2:0], 1'b0};
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        if (in_last) begin
                            idx_q <= '0;
                            cy_q  <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    cy_q  <= chunk_sum[CHUNK];
                    idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Self-checking bench for csa_accum_pipe: directed scenarios plus random
// streams compared against a plain mod 2^WIDTH sum.
module tb_csa_accum_pipe;

    localparam int WIDTH = 184;
    localparam int CHUNK = 46;
    localparam int CNT_W = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int checks = 0;
    int fails  = 0;

    csa_accum_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 64) begin
            tick();
            cycles++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: busy/in_ready/out_valid=%b expected 000", {busy, in_ready, out_valid});
        end
        checks++;
        if (out_sum !== '0 || out_count !== '0) begin
            fails++;
            $display("FAIL reset_regs: out_sum=%h out_count=%0d expected 0/0", out_sum, out_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int cyc;
        in_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_count !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ignores_valid: count=%0d in_ready=%b expected 0/1", out_count, in_ready);
        end
        send_op(WIDTH'(5), 1'b1);
        wait_result(cyc);
        checks++;
        if (cyc !== NCHUNK) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles expected %0d", cyc, NCHUNK);
        end
        checks++;
        if (out_sum !== WIDTH'(5) || out_count !== 8'd1) begin
            fails++;
            $display("FAIL single_result: sum=%h count=%0d expected 5/1", out_sum, out_count);
        end
        take_result();
    endtask

    task automatic test_gaps();
        int cyc;
        logic ready_seen;
        begin_run();
        send_op(WIDTH'(1), 1'b0);
        repeat (2) tick();
        send_op(WIDTH'(2), 1'b0);
        repeat (2) tick();
        send_op(WIDTH'(3), 1'b1);
        ready_seen = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            ready_seen = ready_seen | in_ready;
            tick();
            cyc++;
        end
        checks++;
        if (ready_seen !== 1'b0 || cyc !== NCHUNK) begin
            fails++;
            $display("FAIL gaps_resolve: in_ready_seen=%b cycles=%0d expected 0/%0d", ready_seen, cyc, NCHUNK);
        end
        checks++;
        if (out_sum !== WIDTH'(6) || out_count !== 8'd3) begin
            fails++;
            $display("FAIL gaps_result: sum=%h count=%0d expected 6/3", out_sum, out_count);
        end
        take_result();
    endtask

    task automatic test_carry();
        int cyc;
        logic [WIDTH-1:0] p45, p46, ones;
        p45  = WIDTH'(1) << 45;
        p46  = WIDTH'(1) << 46;
        ones = '1;
        begin_run();
        send_op(p45, 1'b0);
        send_op(p45, 1'b1);
        wait_result(cyc);
        checks++;
        if (out_sum !== p46) begin
            fails++;
            $display("FAIL carry_chunk_boundary: sum=%h expected %h", out_sum, p46);
        end
        take_result();
        begin_run();
        send_op(ones, 1'b0);
        send_op(WIDTH'(1), 1'b1);
        wait_result(cyc);
        checks++;
        if (out_sum !== '0 || out_count !== 8'd2) begin
            fails++;
            $display("FAIL carry_full_wrap: sum=%h count=%0d expected 0/2", out_sum, out_count);
        end
        take_result();
    endtask

    task automatic test_done_hold();
        int cyc;
        int bad;
        logic [WIDTH-1:0] v;
        v = rand_word();
        begin_run();
        send_op(v, 1'b1);
        wait_result(cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start    = i[0];
            in_valid = ~i[0];
            in_data  = rand_word();
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== v || out_count !== 8'd1)
                bad++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL done_hold: %0d bad cycles expected 0", bad);
        end
        start = 1'b1;
        take_result();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_exit: out_valid=%b busy=%b expected 0/0", out_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_sum !== v || out_count !== 8'd1) begin
            fails++;
            $display("FAIL idle_hold: busy=%b sum=%h count=%0d expected 0/%h/1", busy, out_sum, out_count, v);
        end
    endtask

    task automatic test_midrun_reset();
        int cyc;
        begin_run();
        send_op(WIDTH'(100), 1'b0);
        send_op(WIDTH'(200), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_count !== '0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b out_valid=%b count=%0d expected 0/0/0", busy, out_valid, out_count);
        end
        begin_run();
        send_op(WIDTH'(7), 1'b1);
        wait_result(cyc);
        checks++;
        if (out_sum !== WIDTH'(7) || out_count !== 8'd1) begin
            fails++;
            $display("FAIL after_reset_run: sum=%h count=%0d expected 7/1", out_sum, out_count);
        end
        take_result();
    endtask

    task automatic test_random();
        int n, cyc;
        int lens[6] = '{1, 255, 256, 300, 0, 0};
        logic [WIDTH-1:0] ref_sum, d;
        int ref_cnt;
        lens[4] = $urandom_range(2, 120);
        lens[5] = $urandom_range(1, 300);
        for (int r = 0; r < 6; r++) begin
            n = lens[r];
            ref_sum = '0;
            begin_run();
            for (int k = 0; k < n; k++) begin
                d = rand_word();
                ref_sum = ref_sum + d;
                if ($urandom_range(0, 3) == 0) tick();
                send_op(d, (k == n - 1));
            end
            ref_cnt = (n > 255) ? 255 : n;
            wait_result(cyc);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== ref_sum) begin
                fails++;
                $display("FAIL random_sum run%0d n=%0d: sum=%h expected %h", r, n, out_sum, ref_sum);
            end
            checks++;
            if (out_count !== CNT_W'(ref_cnt)) begin
                fails++;
                $display("FAIL random_count run%0d: count=%0d expected %0d", r, out_count, ref_cnt);
            end
            repeat ($urandom_range(0, 3)) tick();
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_carry();
        test_done_hold();
        test_midrun_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/csa_accum_pipe.md
Name: csa_accum_pipe

Overview:
- Parametrised multi-operand carry-save accumulator with a chunked carry-propagate resolve stage, for Montgomery and multiplier partial-product reduction.
- Streams N operands through a registered 3:2 compression row, holding the running total in redundant form as C and S vectors.
- Resolves the total to binary over WIDTH/CHUNK cycles.
- Returns the result over a valid/ready output handshake.

Parameters:
- WIDTH, 184, operand, accumulator and result width. All arithmetic is mod 2^WIDTH.
- CHUNK, 46, bits resolved per cycle in the carry-propagate stage. WIDTH must be an integer multiple of CHUNK. NCHUNK = WIDTH/CHUNK.
- CNT_W, 8, width of the operand counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begins a new accumulation; honoured only in IDLE.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid and in_ready are both high.
- in_data  in  WIDTH  operand.
- in_last  in  1  qualifies in_data as the final operand of the run.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- out_sum  out  WIDTH  binary sum of all accepted operands, mod 2^WIDTH.
- out_count  out  CNT_W  number of operands accepted in this run; saturates at 2^CNT_W-1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state goes to IDLE. C, S, out_sum, out_count, chunk index and resolve carry all become 0. in_ready, out_valid and busy are 0. Reset takes precedence over every other input in any state, including mid-run; any partial result is discarded.
- IDLE:
  - in_ready=0.
  - start=1 → ACCUM; C, S and out_count are cleared on that edge.
  - in_valid is ignored in IDLE, even when start is high in the same cycle.
- ACCUM:
  - in_ready=1. start is ignored.
  - On each accept: S' = S^C^in_data. C' = ((S&C)|(S&in_data)|(C&in_data)) << 1. C'[0]=0 and the carry out of bit WIDTH-1 is discarded.
  - out_count increments per accept, saturating at 2^CNT_W-1.
  - Cycles where in_valid=0 leave all state unchanged.
  - Accept with in_last=1 → RESOLVE; chunk index and resolve carry are cleared on that edge.
- RESOLVE:
  - in_ready=0.
  - Each cycle k = 0..NCHUNK-1: {cy, out_sum[k*CHUNK +: CHUNK]} = S[k*CHUNK +: CHUNK] + C[k*CHUNK +: CHUNK] + cy. cy is registered between chunks.
  - After chunk NCHUNK-1 → DONE. The final carry out is discarded.
  - Latency: out_valid rises exactly NCHUNK cycles after the edge that accepted the in_last operand (4 cycles at the defaults).
- DONE:
  - out_valid=1. out_sum and out_count are held stable until the handshake completes.
  - out_valid&out_ready → IDLE on that edge; out_valid drops in the next cycle. out_sum and out_count keep their values until the next start.
  - start is ignored in DONE. A start asserted in the same cycle as the output handshake is also ignored; it must be reissued in IDLE.
- out_sum is updated only during RESOLVE. Its chunks are partially written and must not be sampled until out_valid=1.
- Modular invariant: in ACCUM, C+S mod 2^WIDTH equals the sum of the accepted operands mod 2^WIDTH after every accept.

Test Plan:
- start; accept a single operand 5 with in_last=1 → out_valid exactly 4 cycles later; out_sum=5; out_count=1.
- Operands 1, 2, 3 (last on 3), with in_valid deasserted for 2 cycles between operands → out_sum=6; out_count=3; in_ready low throughout RESOLVE.
- Operands 2^45 and 2^45 → out_sum=2^46, checking the carry across the chunk 0→1 boundary. Then a new run of 2^184-1 and 1 → out_sum=0, checking the full carry chain and discarded carry-out.
- Hold out_ready=0 for 10 cycles in DONE while pulsing start and in_valid → out_valid stays 1; out_sum and out_count are stable; in_ready=0; no new run starts. Then out_ready=1 → IDLE the next cycle.
- Assert rst after 2 operands accepted in ACCUM → the next cycle shows busy=0, out_valid=0, out_count=0. A fresh run of the single operand 7 → out_sum=7; out_count=1.
- Random streams of 1–300 operands checked against a mod 2^184 reference model → out_sum matches. out_count equals the operand count for runs up to 255 and saturates at 255 beyond that.
